// File: rtl/cnt_cmp_pkg.sv
// Shared types and constants for the counter/comparator sweep sequencer.
package cnt_cmp_pkg;

  localparam int CW_DEF     = 17;
  localparam int DEPTH      = 8;
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int NUM_W      = IDX_W + 1;
  localparam int RES_W      = 16;
  localparam logic [RES_W-1:0] TMO_DEF = 16'hFFFF;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    REPORT,
    DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic [RES_W-1:0] cycles;
  } res_t;

endpackage

// File: rtl/cnt_cmp_timer.sv
// Phase timer: cleared on every phase change, counts while enabled,
// flags when the count reaches the programmed terminal value.
module cnt_cmp_timer
  import cnt_cmp_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [RES_W-1:0] term,
  output logic [RES_W-1:0] cnt,
  output logic             tc
);

  // Counter holds at all-ones instead of wrapping.
  always_ff @(posedge CK or posedge RST) begin
    if (RST)                   cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/cnt_cmp_sweep_ctrl.sv
// Sweeps a small table of compare words through the counter/comparator
// datapath, timing each one until Z or timeout, and reports one result per
// word over a valid/ready channel.
module cnt_cmp_sweep_ctrl
  import cnt_cmp_pkg::*;
#(
  parameter int               CW     = CW_DEF,
  parameter logic [RES_W-1:0] TMO    = TMO_DEF,
  parameter int               SETTLE = SETTLE_DEF
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [CW-1:0]    cfg_data,
  input  logic [NUM_W-1:0] cfg_num,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             dp_en,
  output logic [CW-1:0]    dp_cmp,
  input  logic             dp_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_hit,
  output logic [RES_W-1:0] res_cycles
);

  localparam logic [RES_W-1:0] SETTLE_TC = RES_W'(SETTLE - 1);
  localparam logic [NUM_W-1:0] NUM_MAX   = NUM_W'(DEPTH);

  state_t           state, nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [NUM_W-1:0] num_q, num_nxt;
  res_t             res_q, res_nxt;
  logic [CW-1:0]    tab_q [DEPTH];
  logic             tab_we;
  logic             last;

  logic             t_clr, t_en, t_tc;
  logic [RES_W-1:0] t_term, t_cnt;

  // Same timer serves the settle window and the RUN measurement.
  assign t_en   = (state == LOAD) || (state == RUN);
  assign t_term = (state == LOAD) ? SETTLE_TC : (TMO - 1'b1);
  assign t_clr  = (nxt != state);

  cnt_cmp_timer u_timer (
    .CK   (CK),
    .RST  (RST),
    .clr  (t_clr),
    .en   (t_en),
    .term (t_term),
    .cnt  (t_cnt),
    .tc   (t_tc)
  );

  assign last   = ({1'b0, idx} == (num_q - 1'b1));
  // Writes only land when idle and not colliding with a sweep start.
  assign tab_we = cfg_we && !busy && !((state == IDLE) && start);

  // Table write port; contents survive reset.
  always_ff @(posedge CK) begin
    if (tab_we) tab_q[cfg_addr] <= cfg_data;
  end

  // Next-state, index and result capture; abort overrides everything.
  always_comb begin
    nxt     = state;
    idx_nxt = idx;
    num_nxt = num_q;
    res_nxt = res_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_num == '0) begin
            nxt = DONE;
          end else begin
            nxt     = LOAD;
            idx_nxt = '0;
            num_nxt = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
          end
        end
      end
      LOAD: begin
        if (t_tc) nxt = RUN;
      end
      RUN: begin
        if (dp_z) begin
          nxt     = REPORT;
          res_nxt = '{idx: idx, hit: 1'b1, cycles: t_cnt};
        end else if (t_tc) begin
          nxt     = REPORT;
          res_nxt = '{idx: idx, hit: 1'b0, cycles: TMO};
        end
      end
      REPORT: begin
        if (res_ready) begin
          if (last) begin
            nxt = DONE;
          end else begin
            nxt     = LOAD;
            idx_nxt = idx + 1'b1;
          end
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      nxt     = IDLE;
      idx_nxt = idx;
      num_nxt = num_q;
      res_nxt = res_q;
    end
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      num_q     <= '0;
      res_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dp_en     <= 1'b0;
      dp_cmp    <= '0;
      res_valid <= 1'b0;
    end else begin
      state     <= nxt;
      idx       <= idx_nxt;
      num_q     <= num_nxt;
      res_q     <= res_nxt;
      busy      <= (nxt == LOAD) || (nxt == RUN) || (nxt == REPORT);
      done      <= (nxt == DONE);
      dp_en     <= (nxt == RUN);
      res_valid <= (nxt == REPORT);
      if (nxt == LOAD && state != LOAD) dp_cmp <= tab_q[idx_nxt];
    end
  end

  assign res_idx    = res_q.idx;
  assign res_hit    = res_q.hit;
  assign res_cycles = res_q.cycles;

endmodule
